uart_cmd_host: RTL and testbench



---
 rtl/uart_cmd_host.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_uart_cmd_host.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_host.sv
// rtl/uart_cmd_host.sv - UART command initiator: sends a command frame sequence, collects and checks the response
// Optional feature macro UART_HOST_TIMEOUT_EN: per-byte response timeout of TIMEOUT_BITS bit periods.
module uart_cmd_host #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        CLK,
    input  logic        RST_n,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [1:0]  CMD_TYPE,
    input  logic [7:0]  CMD_ADDR,
    input  logic [7:0]  CMD_DATA,
    input  logic [7:0]  CMD_OPB,
    input  logic [3:0]  CMD_FUN,
    input  logic        PAR_EN,
    input  logic        PAR_TYP,
    output logic        TX_OUT,
    input  logic        RX_IN,
    output logic        RSP_VALID,
    output logic        RSP_ERR,
    output logic [15:0] RSP_DATA
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0] BIT_PAR  = 4'd9;
    localparam logic [3:0] BIT_STOP = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_RSP,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic             r_cmd_ready;
    logic             r_tx_out;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [15:0]      r_rsp_data;

    logic [1:0]       r_type;
    logic [7:0]       r_addr;
    logic [7:0]       r_data;
    logic [7:0]       r_opb;
    logic [3:0]       r_fun;
    logic             r_par_en;
    logic             r_par_typ;

    logic [CNT_W-1:0] r_tx_cnt;
    logic [3:0]       r_tx_bit;
    logic [1:0]       r_tx_byte;

    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_s3;
    logic             r_rx_busy;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [3:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_rx_par_err;
    logic             r_rx_idx;
    logic [7:0]       r_rx_b0;

`ifdef UART_HOST_TIMEOUT_EN
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);
    logic [TO_W-1:0]  r_to_cnt;
`endif

    logic [7:0]       w_tx_byte;
    logic [1:0]       w_tx_last;
    logic             w_rsp_last;
    logic [3:0]       w_tx_next_bit;
    logic [2:0]       w_tx_dm1;
    logic             w_tx_next_val;
    logic [3:0]       w_rx_next_bit;
    logic             w_rx_fall;
    logic             w_rx_err;
    logic             w_start_ok;
    logic             w_to_run;

    // Byte currently on the wire, plus how many command / response bytes this type carries.
    always_comb begin
        w_tx_byte  = 8'h00;
        w_tx_last  = 2'd1;
        w_rsp_last = 1'b1;
        case (r_type)
            2'b00: begin
                w_tx_last = 2'd2;
                case (r_tx_byte)
                    2'd0:    w_tx_byte = 8'hAA;
                    2'd1:    w_tx_byte = r_addr;
                    default: w_tx_byte = r_data;
                endcase
            end
            2'b01: begin
                w_tx_last  = 2'd1;
                w_rsp_last = 1'b0;
                w_tx_byte  = (r_tx_byte == 2'd0) ? 8'hBB : r_addr;
            end
            2'b10: begin
                w_tx_last = 2'd3;
                case (r_tx_byte)
                    2'd0:    w_tx_byte = 8'hCC;
                    2'd1:    w_tx_byte = r_data;
                    2'd2:    w_tx_byte = r_opb;
                    default: w_tx_byte = {4'b0000, r_fun};
                endcase
            end
            default: begin
                w_tx_last = 2'd1;
                w_tx_byte = (r_tx_byte == 2'd0) ? 8'hDD : {4'b0000, r_fun};
            end
        endcase
    end

    always_comb begin
        w_tx_next_bit = (r_tx_bit == 4'd8) ? (r_par_en ? BIT_PAR : BIT_STOP) : r_tx_bit + 4'd1;
        w_tx_dm1      = 3'(w_tx_next_bit - 4'd1);
        if (w_tx_next_bit == BIT_PAR) begin
            w_tx_next_val = ^w_tx_byte ^ r_par_typ;
        end else if (w_tx_next_bit == BIT_STOP) begin
            w_tx_next_val = 1'b1;
        end else begin
            w_tx_next_val = w_tx_byte[w_tx_dm1];
        end
    end

    assign w_rx_next_bit = (r_rx_bit == 4'd8) ? (r_par_en ? BIT_PAR : BIT_STOP) : r_rx_bit + 4'd1;
    assign w_rx_fall     = r_rx_s3 & ~r_rx_s2;
    assign w_rx_err      = r_rx_par_err | ~r_rx_s2;
    assign w_start_ok    = r_rx_busy && (r_rx_bit == 4'd0) && (r_rx_cnt == HALF_LAST) && !r_rx_s2;
    // The timeout keeps running through a start-bit check so a glitch cannot stretch it.
    assign w_to_run      = !r_rx_busy || (r_rx_bit == 4'd0);

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            r_state      <= ST_IDLE;
            r_cmd_ready  <= 1'b0;
            r_tx_out     <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_rsp_data   <= 16'h0000;
            r_type       <= 2'b00;
            r_addr       <= 8'h00;
            r_data       <= 8'h00;
            r_opb        <= 8'h00;
            r_fun        <= 4'h0;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_tx_cnt     <= '0;
            r_tx_bit     <= 4'd0;
            r_tx_byte    <= 2'd0;
            r_rx_s1      <= 1'b1;
            r_rx_s2      <= 1'b1;
            r_rx_s3      <= 1'b1;
            r_rx_busy    <= 1'b0;
            r_rx_cnt     <= '0;
            r_rx_bit     <= 4'd0;
            r_rx_shift   <= 8'h00;
            r_rx_par_err <= 1'b0;
            r_rx_idx     <= 1'b0;
            r_rx_b0      <= 8'h00;
`ifdef UART_HOST_TIMEOUT_EN
            r_to_cnt     <= '0;
`endif
        end else begin
            r_rx_s1     <= RX_IN;
            r_rx_s2     <= r_rx_s1;
            r_rx_s3     <= r_rx_s2;
            r_rsp_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_state     <= ST_IDLE;
                    if (CMD_VALID && r_cmd_ready) begin
                        r_type      <= CMD_TYPE;
                        r_addr      <= CMD_ADDR;
                        r_data      <= CMD_DATA;
                        r_opb       <= CMD_OPB;
                        r_fun       <= CMD_FUN;
                        r_par_en    <= PAR_EN;
                        r_par_typ   <= PAR_TYP;
                        r_cmd_ready <= 1'b0;
                        r_tx_out    <= 1'b0;
                        r_tx_cnt    <= '0;
                        r_tx_bit    <= 4'd0;
                        r_tx_byte   <= 2'd0;
                        r_state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (r_tx_cnt != BIT_LAST) begin
                        r_tx_cnt <= r_tx_cnt + CNT_W'(1);
                    end else begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit != BIT_STOP) begin
                            r_tx_bit <= w_tx_next_bit;
                            r_tx_out <= w_tx_next_val;
                        end else if (r_tx_byte != w_tx_last) begin
                            r_tx_byte <= r_tx_byte + 2'd1;
                            r_tx_bit  <= 4'd0;
                            r_tx_out  <= 1'b0;
                        end else if (r_type == 2'b00) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_data  <= 16'h0000;
                            r_cmd_ready <= 1'b1;
                        end else begin
                            r_state   <= ST_WAIT_RSP;
                            r_rx_busy <= 1'b0;
                            r_rx_idx  <= 1'b0;
`ifdef UART_HOST_TIMEOUT_EN
                            r_to_cnt  <= '0;
`endif
                        end
                    end
                end
                ST_WAIT_RSP: begin
                    if (!r_rx_busy) begin
                        if (w_rx_fall) begin
                            r_rx_busy <= 1'b1;
                            r_rx_cnt  <= '0;
                            r_rx_bit  <= 4'd0;
                        end
                    end else if (r_rx_bit == 4'd0) begin
                        if (r_rx_cnt != HALF_LAST) begin
                            r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                        end else begin
                            r_rx_cnt <= '0;
                            if (r_rx_s2) begin
                                r_rx_busy <= 1'b0;
                            end else begin
                                r_rx_bit     <= 4'd1;
                                r_rx_par_err <= 1'b0;
                            end
                        end
                    end else if (r_rx_cnt != BIT_LAST) begin
                        r_rx_cnt <= r_rx_cnt + CNT_W'(1);
                    end else begin
                        r_rx_cnt <= '0;
                        if (r_rx_bit <= 4'd8) begin
                            r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                            r_rx_bit   <= w_rx_next_bit;
                        end else if (r_rx_bit == BIT_PAR) begin
                            r_rx_par_err <= (r_rx_s2 != (^r_rx_shift ^ r_par_typ));
                            r_rx_bit     <= BIT_STOP;
                        end else begin
                            r_rx_busy <= 1'b0;
                            if (w_rx_err) begin
                                r_state     <= ST_DONE;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b1;
                                r_rsp_data  <= 16'h0000;
                                r_cmd_ready <= 1'b1;
                            end else if (r_rx_idx == w_rsp_last) begin
                                r_state     <= ST_DONE;
                                r_rsp_valid <= 1'b1;
                                r_rsp_err   <= 1'b0;
                                r_rsp_data  <= (r_type == 2'b01) ? {8'h00, r_rx_shift} : {r_rx_shift, r_rx_b0};
                                r_cmd_ready <= 1'b1;
                            end else begin
                                r_rx_b0  <= r_rx_shift;
                                r_rx_idx <= 1'b1;
                            end
                        end
                    end
`ifdef UART_HOST_TIMEOUT_EN
                    if (w_start_ok) begin
                        r_to_cnt <= '0;
                    end else if (w_to_run) begin
                        if (r_to_cnt == TO_LAST) begin
                            r_state     <= ST_DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_data  <= 16'h0000;
                            r_cmd_ready <= 1'b1;
                            r_rx_busy   <= 1'b0;
                        end else begin
                            r_to_cnt <= r_to_cnt + TO_W'(1);
                        end
                    end
`endif
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign CMD_READY = r_cmd_ready;
    assign TX_OUT    = r_tx_out;
    assign RSP_VALID = r_rsp_valid;
    assign RSP_ERR   = r_rsp_err;
    assign RSP_DATA  = r_rsp_data;

endmodule

// File: tb/tb_uart_cmd_host.sv
// tb/tb_uart_cmd_host.sv - directed plus randomized self-checking bench for uart_cmd_host with a frame-level model
module tb_uart_cmd_host;

    localparam int CPB     = 16;
    localparam int TO_BITS = 64;

    logic        CLK       = 1'b0;
    logic        RST_n     = 1'b0;
    logic        CMD_VALID = 1'b0;
    logic        CMD_READY;
    logic [1:0]  CMD_TYPE  = 2'b00;
    logic [7:0]  CMD_ADDR  = 8'h00;
    logic [7:0]  CMD_DATA  = 8'h00;
    logic [7:0]  CMD_OPB   = 8'h00;
    logic [3:0]  CMD_FUN   = 4'h0;
    logic        PAR_EN    = 1'b0;
    logic        PAR_TYP   = 1'b0;
    logic        TX_OUT;
    logic        RX_IN     = 1'b1;
    logic        RSP_VALID;
    logic        RSP_ERR;
    logic [15:0] RSP_DATA;

    uart_cmd_host #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TO_BITS)) dut (
        .CLK(CLK), .RST_n(RST_n), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_TYPE(CMD_TYPE), .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OPB(CMD_OPB),
        .CMD_FUN(CMD_FUN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .TX_OUT(TX_OUT),
        .RX_IN(RX_IN), .RSP_VALID(RSP_VALID), .RSP_ERR(RSP_ERR), .RSP_DATA(RSP_DATA)
    );

    always #5 CLK = ~CLK;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cur      = 0;
    int          c0       = 0;
    logic [7:0]  exp_tx[$];
    logic        got_err;
    logic [15:0] got_data;
    logic        got_v2;
    logic [15:0] got_held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        cur++;
    endtask

    function automatic logic par_bit(input logic [7:0] d, input logic typ);
        return logic'(($countones(d) + int'(typ)) % 2);
    endfunction

    // Frame bits in wire order packed from bit 0 upward: start, data LSB first, [parity], stop.
    function automatic int frame(input logic [7:0] d, input logic pe, input logic pt);
        if (pe) return (1 << 10) | (int'(par_bit(d, pt)) << 9) | (int'(d) << 1);
        return (1 << 9) | (int'(d) << 1);
    endfunction

    task automatic issue(input logic [1:0] t, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] b, input logic [3:0] f, input logic pe, input logic pt);
        int n;
        n = 0;
        CMD_TYPE = t; CMD_ADDR = a; CMD_DATA = d; CMD_OPB = b; CMD_FUN = f;
        PAR_EN = pe; PAR_TYP = pt; CMD_VALID = 1'b1;
        while (CMD_READY !== 1'b1 && n < 200) begin tick(); n++; end
        check("cmd_ready_wait", 32'(CMD_READY), 1);
        tick();
        CMD_VALID = 1'b0;
        CMD_TYPE = 2'($urandom); CMD_ADDR = 8'($urandom); CMD_DATA = 8'($urandom);
        CMD_OPB = 8'($urandom); CMD_FUN = 4'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        c0 = cur;
        check("ready_drop", 32'(CMD_READY), 0);
        check("start_bit_latency", 32'(TX_OUT), 0);
    endtask

    // Samples TX_OUT mid-bit and returns positioned at the first cycle after the last stop bit.
    task automatic capture(input logic pe, input logic pt);
        int nb;
        int total;
        nb    = pe ? 11 : 10;
        total = exp_tx.size() * nb * CPB;
        for (int i = 0; i < exp_tx.size(); i++) begin
            int obs;
            obs = 0;
            for (int k = 0; k < nb; k++) begin
                while (cur - c0 < (i * nb + k) * CPB + CPB / 2) tick();
                obs = obs | (int'(TX_OUT) << k);
            end
            check($sformatf("tx_frame%0d", i), obs, frame(exp_tx[i], pe, pt));
        end
        while (cur - c0 < total - 1) tick();
        check("no_early_rsp", 32'(RSP_VALID), 0);
        tick();
        check("tx_idle", 32'(TX_OUT), 1);
    endtask

    task automatic send_bit(input logic v);
        RX_IN = v;
        repeat (CPB) @(negedge CLK);
    endtask

    task automatic drive_rsp(input logic [7:0] b0, input logic [7:0] b1, input int n,
                             input logic pe, input logic pt, input int bad_idx, input int bad_kind);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = (i == 0) ? b0 : b1;
            p = par_bit(d, pt);
            s = 1'b1;
            if (i == bad_idx && bad_kind == 1) p = ~p;
            if (i == bad_idx && bad_kind == 2) s = 1'b0;
            send_bit(1'b0);
            for (int j = 0; j < 8; j++) send_bit(d[j]);
            if (pe) send_bit(p);
            send_bit(s);
        end
        RX_IN = 1'b1;
    endtask

    task automatic wait_rsp(input int bound, output int waited);
        waited = 0;
        while (RSP_VALID !== 1'b1 && waited < bound) begin tick(); waited++; end
        check("rsp_seen", 32'(RSP_VALID), 1);
        got_err  = RSP_ERR;
        got_data = RSP_DATA;
        tick();
        got_v2   = RSP_VALID;
        got_held = RSP_DATA;
    endtask

    task automatic run_txn(input logic [1:0] t, input logic [7:0] a, input logic [7:0] d,
                           input logic [7:0] b, input logic [3:0] f, input logic pe, input logic pt,
                           input logic [7:0] r0, input logic [7:0] r1, input int bad_idx, input int bad_kind);
        int          nb;
        int          nrsp;
        int          waited;
        logic        exp_err;
        logic [15:0] exp_data;
        nb   = pe ? 11 : 10;
        nrsp = (t == 2'b00) ? 0 : (t == 2'b01) ? 1 : 2;
        exp_tx.delete();
        case (t)
            2'b00: begin exp_tx.push_back(8'hAA); exp_tx.push_back(a); exp_tx.push_back(d); end
            2'b01: begin exp_tx.push_back(8'hBB); exp_tx.push_back(a); end
            2'b10: begin exp_tx.push_back(8'hCC); exp_tx.push_back(d); exp_tx.push_back(b);
                         exp_tx.push_back({4'h0, f}); end
            default: begin exp_tx.push_back(8'hDD); exp_tx.push_back({4'h0, f}); end
        endcase
        exp_err  = (nrsp != 0) && (bad_kind != 0) && (bad_idx < nrsp);
        exp_data = exp_err ? 16'h0000 : (t == 2'b00) ? 16'h0000 : (t == 2'b01) ? {8'h00, r0} : {r1, r0};
        issue(t, a, d, b, f, pe, pt);
        capture(pe, pt);
        if (nrsp == 0) begin
            wait_rsp(4, waited);
            check("write_latency", waited, 0);
        end else begin
            fork
                drive_rsp(r0, r1, nrsp, pe, pt, bad_idx, bad_kind);
                wait_rsp(nrsp * nb * CPB + 64, waited);
            join
            if (!exp_err) check("rsp_latency_window",
                32'(waited >= nrsp * nb * CPB - CPB && waited <= nrsp * nb * CPB), 1);
        end
        check("rsp_err", 32'(got_err), 32'(exp_err));
        check("rsp_data", 32'(got_data), 32'(exp_data));
        check("rsp_pulse_one_cycle", 32'(got_v2), 0);
        check("rsp_data_hold", 32'(got_held), 32'(exp_data));
    endtask

    initial begin
        int waited;

        repeat (3) tick();
        check("rst_tx_out", 32'(TX_OUT), 1);
        check("rst_cmd_ready", 32'(CMD_READY), 0);
        check("rst_rsp_valid", 32'(RSP_VALID), 0);
        check("rst_rsp_err", 32'(RSP_ERR), 0);
        check("rst_rsp_data", 32'(RSP_DATA), 0);
        RST_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(CMD_READY), 1);

        run_txn(2'b00, 8'h02, 8'h81, 8'h00, 4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0);
        run_txn(2'b01, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h5A, 8'h00, 0, 0);
        run_txn(2'b10, 8'h00, 8'h0A, 8'h03, 4'h0, 1'b1, 1'b0, 8'h0D, 8'h00, 0, 0);
        run_txn(2'b01, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'h5A, 8'h00, 0, 1);

        // A 3-cycle low glitch must be rejected; the real byte that follows is then received.
        exp_tx.delete(); exp_tx.push_back(8'hBB); exp_tx.push_back(8'h33);
        issue(2'b01, 8'h33, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1);
        capture(1'b1, 1'b1);
        repeat (100) tick();
        RX_IN = 1'b0; repeat (3) tick(); RX_IN = 1'b1;
        repeat (50) tick();
        check("glitch_no_rsp", 32'(RSP_VALID), 0);
        fork
            drive_rsp(8'hC3, 8'h00, 1, 1'b1, 1'b1, 0, 0);
            wait_rsp(11 * CPB + 64, waited);
        join
        check("glitch_then_err", 32'(got_err), 0);
        check("glitch_then_data", 32'(got_data), 32'h00C3);

`ifdef UART_HOST_TIMEOUT_EN
        exp_tx.delete(); exp_tx.push_back(8'hBB); exp_tx.push_back(8'h44);
        issue(2'b01, 8'h44, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0);
        capture(1'b1, 1'b0);
        repeat (100) tick();
        RX_IN = 1'b0; repeat (3) tick(); RX_IN = 1'b1;
        wait_rsp(2000, waited);
        check("timeout_cycle", waited + 103, TO_BITS * CPB);
        check("timeout_err", 32'(got_err), 1);
        check("timeout_data", 32'(got_data), 0);
`endif

        issue(2'b00, 8'h10, 8'h20, 8'h00, 4'h0, 1'b1, 1'b0);
        while (cur - c0 < CPB / 2) tick();
        check("mid_start_bit", 32'(TX_OUT), 0);
        RST_n = 1'b0;
        tick();
        check("midreset_tx_out", 32'(TX_OUT), 1);
        check("midreset_cmd_ready", 32'(CMD_READY), 0);
        check("midreset_rsp_valid", 32'(RSP_VALID), 0);
        repeat (2) tick();
        RST_n = 1'b1;
        tick();
        check("ready_after_midreset", 32'(CMD_READY), 1);
        run_txn(2'b00, 8'h7E, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 0, 0);

        for (int i = 0; i < 10; i++) begin
            logic [1:0] t;
            logic       pe;
            int         k;
            int         bad_kind;
            t        = 2'($urandom_range(0, 3));
            pe       = 1'($urandom);
            k        = $urandom_range(0, 3);
            bad_kind = (k == 2) ? (pe ? 1 : 2) : (k == 3) ? 2 : 0;
            run_txn(t, 8'($urandom), 8'($urandom), 8'($urandom), 4'($urandom), pe, 1'($urandom),
                    8'($urandom), 8'($urandom), $urandom_range(0, 1), bad_kind);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
